// File: rtl/key_expansion_ctrl.sv
// AES-128 key schedule sequencer: drives a single-round subkey generator one round
// at a time and collects the 11 round keys into a store with a registered read port.
module key_expansion_ctrl #(
    parameter int KEY_LEN    = 128,
    parameter int WORD_LEN   = 32,
    parameter int NUM_ROUNDS = 10,
    parameter int TIMEOUT    = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [KEY_LEN-1:0]  key_in,
    input  logic                key_valid,
    output logic                busy,
    output logic                done,
    output logic                keys_ready,
    output logic                error,
    output logic [KEY_LEN-1:0]  sk_data_out,
    output logic [WORD_LEN-1:0] sk_rcon,
    output logic                sk_valid_out,
    input  logic [KEY_LEN-1:0]  sk_data_in,
    input  logic                sk_valid_in,
    input  logic [3:0]          rd_addr,
    output logic [KEY_LEN-1:0]  rd_key
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;

    localparam int TW = $clog2(TIMEOUT + 1);

    logic [2:0]         state;
    logic [3:0]         round;
    logic [TW-1:0]      timer;
    logic [KEY_LEN-1:0] store [NUM_ROUNDS+1];

    function automatic logic [7:0] rc(input logic [3:0] r);
        case (r)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
    endfunction

    assign sk_valid_out = (state == S_ISSUE);
    assign done         = (state == S_DONE);
    assign error        = (state == S_ERR);
    assign busy         = (state == S_ISSUE) || (state == S_WAIT) || (state == S_DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            round       <= '0;
            timer       <= '0;
            keys_ready  <= 1'b0;
            sk_data_out <= '0;
            sk_rcon     <= '0;
            rd_key      <= '0;
            for (int i = 0; i <= NUM_ROUNDS; i++) store[i] <= '0;
        end else begin
            // Read sees the pre-write value when the same entry is written this cycle.
            rd_key <= (rd_addr <= 4'(NUM_ROUNDS)) ? store[rd_addr] : '0;
            case (state)
                S_IDLE, S_ERR: begin
                    if (key_valid) begin
                        store[0]    <= key_in;
                        round       <= 4'd1;
                        keys_ready  <= 1'b0;
                        sk_data_out <= key_in;
                        sk_rcon     <= {rc(4'd1), {(WORD_LEN-8){1'b0}}};
                        state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    timer <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    timer <= timer + TW'(1);
                    // A result arriving on the last allowed cycle beats the timeout.
                    if (sk_valid_in) begin
                        store[round] <= sk_data_in;
                        if (round == 4'(NUM_ROUNDS)) begin
                            state <= S_DONE;
                        end else begin
                            round       <= round + 4'd1;
                            sk_data_out <= sk_data_in;
                            sk_rcon     <= {rc(round + 4'd1), {(WORD_LEN-8){1'b0}}};
                            state       <= S_ISSUE;
                        end
                    end else if (timer == TW'(TIMEOUT - 1)) begin
                        state <= S_ERR;
                    end
                end
                S_DONE: begin
                    keys_ready <= 1'b1;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_key_expansion_ctrl.sv
// Directed bench for key_expansion_ctrl: FIPS-197 key schedule returned by a
// lookup-based generator model with programmable latency.
module tb_key_expansion_ctrl;

    logic         clk = 1'b0;
    logic         reset;
    logic [127:0] key_in;
    logic         key_valid;
    logic         busy, done, keys_ready, error;
    logic [127:0] sk_data_out;
    logic [31:0]  sk_rcon;
    logic         sk_valid_out;
    logic [127:0] sk_data_in;
    logic         sk_valid_in;
    logic [3:0]   rd_addr;
    logic [127:0] rd_key;

    key_expansion_ctrl dut (
        .clk(clk), .reset(reset), .key_in(key_in), .key_valid(key_valid),
        .busy(busy), .done(done), .keys_ready(keys_ready), .error(error),
        .sk_data_out(sk_data_out), .sk_rcon(sk_rcon), .sk_valid_out(sk_valid_out),
        .sk_data_in(sk_data_in), .sk_valid_in(sk_valid_in),
        .rd_addr(rd_addr), .rd_key(rd_key)
    );

    always #5 clk = ~clk;

    logic [127:0] rk [11] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    logic [7:0] rcv [11] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                             8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int gen_lat = 4;
    int gen_drop = 0;
    int pulses = 0;
    int issue_cyc [11];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Generator model: answers each request gen_lat cycles later with the FIPS round key.
    initial begin
        int pend;
        logic [127:0] pdata;
        pend = 0;
        pdata = '0;
        sk_valid_in = 1'b0;
        sk_data_in = '0;
        forever begin
            @(negedge clk);
            sk_valid_in = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    sk_valid_in = 1'b1;
                    sk_data_in = pdata;
                end
            end
            if (sk_valid_out) begin
                pulses++;
                if (pulses > 10) begin
                    chk("extra_issue", 128'(pulses), 128'd10);
                end else begin
                    issue_cyc[pulses] = cyc;
                    chk($sformatf("rcon_r%0d", pulses), 128'(sk_rcon), {96'h0, rcv[pulses], 24'h0});
                    chk($sformatf("prev_key_r%0d", pulses), sk_data_out, rk[pulses-1]);
                    if (pulses > 1)
                        chk($sformatf("period_r%0d", pulses), 128'(issue_cyc[pulses] - issue_cyc[pulses-1]),
                            128'(gen_lat + 1));
                    if (pulses != gen_drop) begin
                        pend = gen_lat;
                        pdata = rk[pulses];
                    end
                end
            end
        end
    end

    task automatic start_key(input logic [127:0] k);
        pulses = 0;
        @(negedge clk);
        key_in = k;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int dn;
        int n;
        dn = 0;
        n = 0;
        while (!keys_ready && n < 600) begin
            @(negedge clk);
            if (done) dn++;
            n++;
        end
        chk({tag, "_ready"}, 128'(keys_ready), 128'd1);
        chk({tag, "_done_pulses"}, 128'(dn), 128'd1);
        chk({tag, "_issues"}, 128'(pulses), 128'd10);
        chk({tag, "_busy_low"}, 128'(busy), 128'd0);
    endtask

    task automatic read_sweep(input string tag);
        for (int a = 0; a < 16; a++) begin
            @(negedge clk);
            rd_addr = 4'(a);
            @(negedge clk);
            chk($sformatf("%s_rd%0d", tag, a), rd_key, (a <= 10) ? rk[a] : 128'h0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic chk_outs_zero(input string tag);
        chk({tag, "_flags"}, 128'({busy, done, keys_ready, error, sk_valid_out}), 128'd0);
        chk({tag, "_sk_data_out"}, sk_data_out, 128'h0);
        chk({tag, "_sk_rcon"}, 128'(sk_rcon), 128'h0);
        chk({tag, "_rd_key"}, rd_key, 128'h0);
    endtask

    initial begin
        int n;
        int err_cyc;
        reset = 1'b1;
        key_in = '0;
        key_valid = 1'b0;
        rd_addr = '0;
        repeat (3) @(negedge clk);
        chk_outs_zero("reset");
        reset = 1'b0;

        // L=4 nominal expansion plus read sweep (includes addresses 11..15)
        gen_lat = 4;
        start_key(rk[0]);
        chk("busy_after_accept", 128'(busy), 128'd1);
        wait_ready("l4");
        read_sweep("l4");

        // L=1 and L=20 from a cleared store
        do_reset();
        gen_lat = 1;
        start_key(rk[0]);
        wait_ready("l1");
        read_sweep("l1");
        do_reset();
        gen_lat = 20;
        start_key(rk[0]);
        wait_ready("l20");
        read_sweep("l20");

        // a different key during round 5 must be ignored
        do_reset();
        gen_lat = 4;
        start_key(rk[0]);
        n = 0;
        while (pulses < 5 && n < 200) begin @(negedge clk); n++; end
        key_in = 128'h000102030405060708090a0b0c0d0e0f;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        wait_ready("ign");
        read_sweep("ign");

        // round 3 never answered: 64 WAIT cycles then ERR
        gen_drop = 3;
        start_key(rk[0]);
        n = 0;
        err_cyc = 0;
        while (!error && n < 300) begin @(negedge clk); n++; end
        err_cyc = cyc;
        chk("err_set", 128'(error), 128'd1);
        chk("err_delay", 128'(err_cyc - issue_cyc[3]), 128'd65);
        chk("err_busy", 128'(busy), 128'd0);
        chk("err_ready", 128'(keys_ready), 128'd0);
        repeat (5) @(negedge clk);
        chk("err_sticky", 128'(error), 128'd1);
        gen_drop = 0;
        start_key(rk[0]);
        chk("err_cleared", 128'(error), 128'd0);
        wait_ready("rec");
        read_sweep("rec");

        // reset during WAIT of round 7, then restart from round 1
        start_key(rk[0]);
        n = 0;
        while (pulses < 7 && n < 200) begin @(negedge clk); n++; end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_outs_zero("midrst");
        repeat (30) @(negedge clk);
        chk("midrst_no_issue", 128'(pulses), 128'd7);
        chk("midrst_idle", 128'(busy), 128'd0);
        start_key(rk[0]);
        wait_ready("restart");
        read_sweep("restart");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
